// File: rtl/dw_conv_pkg.sv
// Shared types and helpers for the depthwise-conv line/window block.
// Holds default sizing constants, the stride encoding and the window bit-offset function.
package dw_conv_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CH         = 18;
    localparam int unsigned DEF_K          = 3;

    typedef enum logic {
        STRIDE1 = 1'b0,
        STRIDE2 = 1'b1
    } stride_e;

    // Bit offset of sample (c, r, k) in a flattened CH x K x K window.
    function automatic int unsigned win_bit(input int unsigned c, input int unsigned r,
                                            input int unsigned k, input int unsigned kk,
                                            input int unsigned dw);
        return ((c * kk + r) * kk + k) * dw;
    endfunction

endpackage

// File: rtl/dw_line_buf.sv
// K-1 circular line rows sharing one column address; row i takes row i-1's old value.
// Reads are combinational, so a same-address write in this cycle is seen only next cycle.
module dw_line_buf #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ROWS      = 2,
    parameter int unsigned DEPTH     = 320,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [ROWS*WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ROWS][DEPTH];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < ROWS; i++) begin
            rdata[i*WIDTH +: WIDTH] = mem[i][addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][addr] <= wdata;
            for (int i = 1; i < ROWS; i++) begin
                mem[i][addr] <= mem[i-1][addr];
            end
        end
    end

endmodule

// File: rtl/dw_conv_line_window.sv
// Raster pixel stream in, one K x K window per channel out, valid convolution with stride 1/2.
// Line buffering, window shift register, frame counters and the output handshake live here.
module dw_conv_line_window
    import dw_conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CH         = DEF_CH,
    parameter int unsigned K          = DEF_K,
    parameter int unsigned MAX_WIDTH  = 320,
    parameter int unsigned MAX_HEIGHT = 320,
    parameter int unsigned W_BITS     = $clog2(MAX_WIDTH + 1),
    parameter int unsigned H_BITS     = $clog2(MAX_HEIGHT + 1)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_start,
    input  logic [W_BITS-1:0]              cfg_width,
    input  logic [H_BITS-1:0]              cfg_height,
    input  logic                           cfg_stride2,
    input  logic [CH*DATA_WIDTH-1:0]       in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CH*K*K*DATA_WIDTH-1:0]   win_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int unsigned PIX_W = CH * DATA_WIDTH;
    localparam int unsigned WIN_W = PIX_W * K * K;
    localparam logic [W_BITS-1:0] COL_FIRST = W_BITS'(K - 1);
    localparam logic [H_BITS-1:0] ROW_FIRST = H_BITS'(K - 1);
    localparam logic [W_BITS-1:0] W_ONE     = W_BITS'(1);
    localparam logic [H_BITS-1:0] H_ONE     = H_BITS'(1);

    logic [W_BITS-1:0]      width_q, col_q, col_off;
    logic [H_BITS-1:0]      height_q, row_q, row_off;
    stride_e                stride_q;
    logic                   busy_q, out_valid_q, frame_done_q;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [(K-1)*PIX_W-1:0] line_rd;
    logic [K*PIX_W-1:0]     new_col;
    logic                   accept, last_col, last_pix, emit;

    // A new config pulse blocks acceptance so the restarted frame begins cleanly.
    assign in_ready = busy_q && !cfg_start && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == width_q - W_ONE);
    assign last_pix = last_col && (row_q == height_q - H_ONE);
    assign col_off  = col_q - COL_FIRST;
    assign row_off  = row_q - ROW_FIRST;
    assign emit     = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST) &&
                      ((stride_q == STRIDE1) || (!col_off[0] && !row_off[0]));

    dw_line_buf #(
        .WIDTH     (PIX_W),
        .ROWS      (K - 1),
        .DEPTH     (MAX_WIDTH),
        .ADDR_BITS (W_BITS)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (in_data),
        .rdata (line_rd)
    );

    // Right-hand window column, slot 0 = oldest row, slot K-1 = incoming pixel.
    always_comb begin
        new_col = '0;
        new_col[(K-1)*PIX_W +: PIX_W] = in_data;
        for (int i = 0; i < K - 1; i++) begin
            new_col[(K-2-i)*PIX_W +: PIX_W] = line_rd[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        win_d = win_q;
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K - 1; k++) begin
                    win_d[win_bit(c, r, k, K, DATA_WIDTH) +: DATA_WIDTH] =
                        win_q[win_bit(c, r, k + 1, K, DATA_WIDTH) +: DATA_WIDTH];
                end
                win_d[win_bit(c, r, K - 1, K, DATA_WIDTH) +: DATA_WIDTH] =
                    new_col[(r*CH + c)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            width_q      <= '0;
            height_q     <= '0;
            stride_q     <= STRIDE1;
            col_q        <= '0;
            row_q        <= '0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (cfg_start) begin
                width_q     <= cfg_width;
                height_q    <= cfg_height;
                stride_q    <= cfg_stride2 ? STRIDE2 : STRIDE1;
                col_q       <= '0;
                row_q       <= '0;
                busy_q      <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                if (accept) begin
                    win_q <= win_d;
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= last_pix ? '0 : row_q + H_ONE;
                    end else begin
                        col_q <= col_q + W_ONE;
                    end
                    if (last_pix) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                if (accept && emit) begin
                    out_valid_q <= 1'b1;
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign win_data   = win_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dw_conv_line_window.sv
// Scoreboard bench: a small 1-channel K=3 instance for directed frames and a
// CH=18 K=5 full-width instance driven with random data and random handshakes.
module tb_dw_conv_line_window;

    localparam int DW    = 8;
    localparam int A_CH  = 1;
    localparam int A_K   = 3;
    localparam int B_CH  = 18;
    localparam int B_K   = 5;
    localparam int WA    = A_CH * A_K * A_K * DW;
    localparam int WB    = B_CH * B_K * B_K * DW;
    localparam int B_PIX = B_CH * DW;
    localparam int BW    = 320;
    localparam int BH    = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             a_cfg_start, a_cfg_stride2, a_in_valid, a_in_ready;
    logic [8:0]       a_cfg_width, a_cfg_height;
    logic [7:0]       a_in_data;
    logic [WA-1:0]    a_win_data;
    logic             a_out_valid, a_out_ready, a_frame_done, a_busy;

    logic             b_cfg_start, b_cfg_stride2, b_in_valid, b_in_ready;
    logic [8:0]       b_cfg_width, b_cfg_height;
    logic [B_PIX-1:0] b_in_data;
    logic [WB-1:0]    b_win_data;
    logic             b_out_valid, b_out_ready, b_frame_done, b_busy;

    dw_conv_line_window #(
        .DATA_WIDTH (DW), .CH (A_CH), .K (A_K), .MAX_WIDTH (320), .MAX_HEIGHT (320)
    ) u_dut_a (
        .clk (clk), .rstn (rstn), .cfg_start (a_cfg_start), .cfg_width (a_cfg_width),
        .cfg_height (a_cfg_height), .cfg_stride2 (a_cfg_stride2), .in_data (a_in_data),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .win_data (a_win_data),
        .out_valid (a_out_valid), .out_ready (a_out_ready), .frame_done (a_frame_done),
        .busy (a_busy)
    );

    dw_conv_line_window #(
        .DATA_WIDTH (DW), .CH (B_CH), .K (B_K), .MAX_WIDTH (320), .MAX_HEIGHT (320)
    ) u_dut_b (
        .clk (clk), .rstn (rstn), .cfg_start (b_cfg_start), .cfg_width (b_cfg_width),
        .cfg_height (b_cfg_height), .cfg_stride2 (b_cfg_stride2), .in_data (b_in_data),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .win_data (b_win_data),
        .out_valid (b_out_valid), .out_ready (b_out_ready), .frame_done (b_frame_done),
        .busy (b_busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int a_wins = 0, a_fd = 0, b_wins = 0, b_fd = 0;
    logic [WA-1:0] a_q[$];
    logic [WB-1:0] b_q[$];
    logic [B_PIX-1:0] bpix [BW*BH];

    task automatic chk_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    task automatic chk_win(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else begin
            int idx = 0;
            for (int i = WB / DW - 1; i >= 0; i--) begin
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) idx = i;
            end
            $display("FAIL %s: sample %0d got %0h want %0h", name, idx,
                     act[idx*DW +: DW], exp[idx*DW +: DW]);
        end
    endtask

    task automatic fail_timeout(input string name);
        total_cnt++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    // Monitors: pop the expected window whenever a handshake will complete at the next edge.
    always @(negedge clk) begin
        if (a_frame_done) a_fd++;
        if (a_out_valid && a_out_ready) begin
            a_wins++;
            if (a_q.size() == 0) begin
                total_cnt++;
                $display("FAIL a_win: got unexpected window %0h want none", a_win_data);
            end else begin
                chk_win("a_win", WB'(a_win_data), WB'(a_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (b_frame_done) b_fd++;
        if (b_out_valid && b_out_ready) begin
            b_wins++;
            if (b_q.size() == 0) begin
                total_cnt++;
                $display("FAIL b_win: got unexpected window want none");
            end else begin
                chk_win("b_win", b_win_data, b_q.pop_front());
            end
        end
    end

    // Window at (row, col) of a frame whose pixel value is its raster index.
    task automatic a_expect_frame(input int w, input int h, input bit s2);
        for (int row = A_K - 1; row < h; row++) begin
            for (int col = A_K - 1; col < w; col++) begin
                logic [WA-1:0] v;
                v = '0;
                if (!s2 || (((row - 2) % 2) == 0 && ((col - 2) % 2) == 0)) begin
                    for (int r = 0; r < A_K; r++) begin
                        for (int k = 0; k < A_K; k++) begin
                            v[(r*A_K + k)*DW +: DW] = 8'((row - 2 + r) * w + (col - 2 + k));
                        end
                    end
                    a_q.push_back(v);
                end
            end
        end
    endtask

    task automatic b_expect_frame();
        for (int row = B_K - 1; row < BH; row++) begin
            for (int col = B_K - 1; col < BW; col++) begin
                logic [WB-1:0] v;
                v = '0;
                for (int c = 0; c < B_CH; c++) begin
                    for (int r = 0; r < B_K; r++) begin
                        for (int k = 0; k < B_K; k++) begin
                            v[((c*B_K + r)*B_K + k)*DW +: DW] =
                                bpix[(row - B_K + 1 + r)*BW + col - B_K + 1 + k][c*DW +: DW];
                        end
                    end
                end
                b_q.push_back(v);
            end
        end
    endtask

    task automatic a_config(input int w, input int h, input bit s2);
        a_cfg_width = 9'(w);
        a_cfg_height = 9'(h);
        a_cfg_stride2 = s2;
        a_cfg_start = 1'b1;
        @(posedge clk); #1;
        a_cfg_start = 1'b0;
    endtask

    task automatic a_send(input int first, input int last, input bit watch);
        for (int p = first; p <= last; p++) begin
            int guard;
            guard = 0;
            a_in_data = 8'(p);
            a_in_valid = 1'b1;
            @(negedge clk);
            while (!a_in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!a_in_ready) begin
                a_in_valid = 1'b0;
                fail_timeout("a_send");
                return;
            end
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            if (watch && (p == 11 || p == 12)) begin
                @(negedge clk);
                chk_bit(p == 12 ? "valid_after_px12" : "no_valid_after_px11", a_out_valid,
                        p == 12);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic a_drain(input string name);
        int guard = 0;
        @(negedge clk);
        while ((a_q.size() != 0 || a_busy || a_out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk_int({name, "_queue_left"}, a_q.size(), 0);
        chk_bit({name, "_busy_end"}, a_busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic a_stall_ctl();
        int guard = 0;
        @(negedge clk);
        while (!a_out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!a_out_valid) fail_timeout("s3_first_window");
        else begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                chk_win("s3_hold_win", WB'(a_win_data), WB'(a_q[0]));
                chk_bit("s3_hold_in_ready", a_in_ready, 1'b0);
            end
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
    endtask

    task automatic b_drive();
        int p = 0;
        int guard = 0;
        while (p < BW * BH && guard < 20000) begin
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_in_data = bpix[p];
            b_out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (b_in_valid && b_in_ready) p++;
            @(posedge clk); #1;
            guard++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        if (p != BW * BH) fail_timeout("s6_send");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, w0, guard;
        a_cfg_start = 0; a_cfg_width = '0; a_cfg_height = '0; a_cfg_stride2 = 0;
        a_in_data = '0; a_in_valid = 0; a_out_ready = 1;
        b_cfg_start = 0; b_cfg_width = '0; b_cfg_height = '0; b_cfg_stride2 = 0;
        b_in_data = '0; b_in_valid = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        chk_bit("rst_out_valid", a_out_valid, 1'b0);
        chk_bit("rst_busy", a_busy, 1'b0);
        chk_bit("rst_in_ready", a_in_ready, 1'b0);
        chk_bit("rst_frame_done", a_frame_done, 1'b0);
        chk_win("rst_win_data", WB'(a_win_data), '0);
        chk_bit("rst_b_out_valid", b_out_valid, 1'b0);
        @(posedge clk); #1;

        // Stream run, stride 1.
        fd0 = a_fd; w0 = a_wins;
        a_config(5, 4, 0);
        a_expect_frame(5, 4, 0);
        a_send(0, 19, 1);
        a_drain("s1");
        chk_int("s1_windows", a_wins - w0, 6);
        chk_int("s1_frame_done", a_fd - fd0, 1);

        // Stride 2.
        fd0 = a_fd; w0 = a_wins;
        a_config(5, 4, 1);
        a_expect_frame(5, 4, 1);
        a_send(0, 19, 0);
        a_drain("s2");
        chk_int("s2_windows", a_wins - w0, 2);
        chk_int("s2_frame_done", a_fd - fd0, 1);

        // Backpressure on the first window.
        fd0 = a_fd; w0 = a_wins;
        a_config(5, 4, 0);
        a_expect_frame(5, 4, 0);
        a_out_ready = 1'b0;
        fork
            a_send(0, 19, 0);
            a_stall_ctl();
        join
        a_drain("s3");
        chk_int("s3_windows", a_wins - w0, 6);
        chk_int("s3_frame_done", a_fd - fd0, 1);

        // Reset mid-frame after pixel 9.
        a_config(5, 4, 0);
        a_send(0, 9, 0);
        a_in_valid = 1'b1;
        a_in_data = 8'd99;
        rstn = 1'b0;
        @(negedge clk);
        chk_bit("s4_rst_out_valid", a_out_valid, 1'b0);
        chk_bit("s4_rst_busy", a_busy, 1'b0);
        chk_bit("s4_rst_in_ready", a_in_ready, 1'b0);
        chk_bit("s4_rst_frame_done", a_frame_done, 1'b0);
        chk_win("s4_rst_win_data", WB'(a_win_data), '0);
        @(negedge clk);
        rstn = 1'b1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        fd0 = a_fd; w0 = a_wins;
        a_config(5, 4, 0);
        a_expect_frame(5, 4, 0);
        a_send(0, 19, 1);
        a_drain("s4");
        chk_int("s4_windows", a_wins - w0, 6);
        chk_int("s4_frame_done", a_fd - fd0, 1);

        // Restart while a window is pending.
        fd0 = a_fd; w0 = a_wins;
        a_out_ready = 1'b0;
        a_config(5, 4, 0);
        a_send(0, 12, 0);
        @(negedge clk);
        chk_bit("s5_pending", a_out_valid, 1'b1);
        @(posedge clk); #1;
        a_config(5, 4, 0);
        @(negedge clk);
        chk_bit("s5_dropped", a_out_valid, 1'b0);
        chk_bit("s5_busy", a_busy, 1'b1);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_expect_frame(5, 4, 0);
        a_send(0, 19, 0);
        a_drain("s5");
        chk_int("s5_windows", a_wins - w0, 6);
        chk_int("s5_frame_done", a_fd - fd0, 1);

        // Full-width multichannel frame with random handshakes.
        for (int i = 0; i < BW * BH; i++) begin
            for (int c = 0; c < B_CH; c++) bpix[i][c*DW +: DW] = 8'($urandom);
        end
        b_expect_frame();
        b_cfg_width = 9'(BW);
        b_cfg_height = 9'(BH);
        b_cfg_stride2 = 1'b0;
        b_cfg_start = 1'b1;
        @(posedge clk); #1;
        b_cfg_start = 1'b0;
        b_drive();
        guard = 0;
        @(negedge clk);
        while ((b_q.size() != 0 || b_busy || b_out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk_int("s6_queue_left", b_q.size(), 0);
        chk_int("s6_windows", b_wins, 2 * 316);
        chk_int("s6_frame_done", b_fd, 1);
        chk_bit("s6_busy_end", b_busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
